// File: rtl/axi_fir_coeff_reload_rx_if.sv
// Reload and config AXI-Stream bundle for the FIR coefficient reload receiver.
// The master drives data/valid and the slave returns ready.
interface axi_fir_coeff_reload_rx_if #(
  parameter int unsigned COEFF_WIDTH  = 16,
  parameter int unsigned CONFIG_WIDTH = 8
);
  logic [COEFF_WIDTH-1:0]  s_axis_reload_tdata;
  logic                    s_axis_reload_tlast;
  logic                    s_axis_reload_tvalid;
  logic                    s_axis_reload_tready;
  logic [CONFIG_WIDTH-1:0] s_axis_config_tdata;
  logic                    s_axis_config_tvalid;
  logic                    s_axis_config_tready;

  modport master (
    output s_axis_reload_tdata,
    output s_axis_reload_tlast,
    output s_axis_reload_tvalid,
    input  s_axis_reload_tready,
    output s_axis_config_tdata,
    output s_axis_config_tvalid,
    input  s_axis_config_tready
  );

  modport slave (
    input  s_axis_reload_tdata,
    input  s_axis_reload_tlast,
    input  s_axis_reload_tvalid,
    output s_axis_reload_tready,
    input  s_axis_config_tdata,
    input  s_axis_config_tvalid,
    output s_axis_config_tready
  );
endinterface

// File: rtl/axi_fir_coeff_reload_rx.sv
// Double-buffered FIR coefficient reload receiver: fills the shadow bank, swaps on config.
// Define FIR_RELOAD_REVERSE_EN to write taps in reverse order (first beat = last tap).
module axi_fir_coeff_reload_rx #(
  parameter int unsigned NUM_TAPS     = 129,
  parameter int unsigned COEFF_WIDTH  = 16,
  parameter int unsigned CONFIG_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  axi_fir_coeff_reload_rx_if.slave    axis,
  input  logic [ADDR_WIDTH-1:0]       coeff_raddr,
  output logic [COEFF_WIDTH-1:0]      coeff_rdata,
  output logic [CONFIG_WIDTH-1:0]     config_word,
  output logic                        active_bank,
  output logic                        reload_done,
  output logic                        err_short,
  output logic                        err_long
);

  localparam int unsigned IdxW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [ADDR_WIDTH:0] TapsCnt = (ADDR_WIDTH+1)'(NUM_TAPS);
  localparam logic [ADDR_WIDTH:0] LastTap = (ADDR_WIDTH+1)'(NUM_TAPS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH:0]     wr_cnt_q, wr_cnt_d;
  logic                    active_bank_q, active_bank_d;
  logic [CONFIG_WIDTH-1:0] config_word_q, config_word_d;
  logic [COEFF_WIDTH-1:0]  rdata_q, rdata_d;
  logic                    reload_done_q, reload_done_d;
  logic                    err_short_q, err_short_d;
  logic                    err_long_q, err_long_d;

  logic [COEFF_WIDTH-1:0]  mem_q [2][NUM_TAPS];

  logic                    reload_tready;
  logic                    config_tready;
  logic                    beat;
  logic                    cfg_fire;
  logic                    wr_en;
  logic                    last_tap;
  logic [ADDR_WIDTH:0]     cnt_inc;
  logic [IdxW-1:0]         wr_addr;

  always_comb begin
    reload_tready = (state_q != StFull);
    config_tready = (state_q == StIdle) || (state_q == StFull);
    beat          = axis.s_axis_reload_tvalid && reload_tready;
    cfg_fire      = axis.s_axis_config_tvalid && config_tready;
    cnt_inc       = wr_cnt_q + 1'b1;
    last_tap      = (cnt_inc == TapsCnt);
    // Writes are gated during reset so an aborted packet leaves no partial beat behind.
    wr_en         = beat && aresetn && ((state_q == StIdle) || (state_q == StLoad));
  end

`ifdef FIR_RELOAD_REVERSE_EN
  assign wr_addr = IdxW'(LastTap - wr_cnt_q);
`else
  assign wr_addr = IdxW'(wr_cnt_q);
`endif

  assign axis.s_axis_reload_tready = reload_tready;
  assign axis.s_axis_config_tready = config_tready;

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    active_bank_d = active_bank_q;
    config_word_d = config_word_q;
    reload_done_d = 1'b0;
    err_short_d   = 1'b0;
    err_long_d    = 1'b0;

    case (state_q)
      StIdle, StLoad: begin
        if (beat) begin
          if (axis.s_axis_reload_tlast) begin
            if (last_tap) begin
              state_d       = StFull;
              wr_cnt_d      = cnt_inc;
              reload_done_d = 1'b1;
            end else begin
              state_d     = StIdle;
              wr_cnt_d    = '0;
              err_short_d = 1'b1;
            end
          end else begin
            wr_cnt_d = cnt_inc;
            state_d  = last_tap ? StDrain : StLoad;
          end
        end
      end
      StFull: begin
        if (cfg_fire) begin
          active_bank_d = ~active_bank_q;
          wr_cnt_d      = '0;
          state_d       = StIdle;
        end
      end
      StDrain: begin
        if (beat && axis.s_axis_reload_tlast) begin
          state_d    = StIdle;
          wr_cnt_d   = '0;
          err_long_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cfg_fire) begin
      config_word_d = axis.s_axis_config_tdata;
    end
  end

  // Bank select is the registered value, so a read issued on the swap cycle sees the old bank.
  always_comb begin
    rdata_d = '0;
    if ({1'b0, coeff_raddr} < TapsCnt) begin
      rdata_d = mem_q[active_bank_q][coeff_raddr[IdxW-1:0]];
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[~active_bank_q][wr_addr] <= axis.s_axis_reload_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      wr_cnt_q      <= '0;
      active_bank_q <= 1'b0;
      config_word_q <= '0;
      rdata_q       <= '0;
      reload_done_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      active_bank_q <= active_bank_d;
      config_word_q <= config_word_d;
      rdata_q       <= rdata_d;
      reload_done_q <= reload_done_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
    end
  end

  assign coeff_rdata = rdata_q;
  assign config_word = config_word_q;
  assign active_bank = active_bank_q;
  assign reload_done = reload_done_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;

endmodule

// File: tb/tb_axi_fir_coeff_reload_rx.sv
// Directed bench for axi_fir_coeff_reload_rx: reference coefficient banks plus a read scoreboard.
// Honours FIR_RELOAD_REVERSE_EN for the expected tap order.
module tb_axi_fir_coeff_reload_rx;
  localparam int unsigned NumTaps = 129;
  localparam int unsigned CW      = 16;
  localparam int unsigned CfgW    = 8;
  localparam int unsigned AW      = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_fir_coeff_reload_rx_if #(.COEFF_WIDTH(CW), .CONFIG_WIDTH(CfgW)) axis_if ();

  logic [AW-1:0]   raddr;
  logic [CW-1:0]   rdata;
  logic [CfgW-1:0] cfg_word;
  logic            bank;
  logic            done;
  logic            e_short;
  logic            e_long;

  axi_fir_coeff_reload_rx #(
    .NUM_TAPS    (NumTaps),
    .COEFF_WIDTH (CW),
    .CONFIG_WIDTH(CfgW),
    .ADDR_WIDTH  (AW)
  ) dut (
    .aclk       (clk),
    .aresetn    (rst_n),
    .axis       (axis_if.slave),
    .coeff_raddr(raddr),
    .coeff_rdata(rdata),
    .config_word(cfg_word),
    .active_bank(bank),
    .reload_done(done),
    .err_short  (e_short),
    .err_long   (e_long)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   ref_mem [2][NumTaps];
  logic ref_bank;
  int   exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int tap_addr(input int i);
`ifdef FIR_RELOAD_REVERSE_EN
    return NumTaps - 1 - i;
`else
    return i;
`endif
  endfunction

  function automatic int exp_rd(input int a);
    if (a < NumTaps) return ref_mem[ref_bank][a];
    return 0;
  endfunction

  task automatic read_issue(input int a);
    raddr = AW'(a);
    exp_q.push_back(exp_rd(a));
  endtask

  task automatic read_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed read with no expected value queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(rdata), e);
    end
  endtask

  // Drives n beats back to back; cfg_at >= 0 raises config valid at that beat and leaves it high.
  task automatic send_packet(input int n, input int base, input int cfg_at, input bit with_last,
                             input string tag);
    for (int i = 0; i < n; i++) begin
      axis_if.s_axis_reload_tdata  = CW'(base + i);
      axis_if.s_axis_reload_tlast  = with_last && (i == n - 1);
      axis_if.s_axis_reload_tvalid = 1'b1;
      if (i == cfg_at) axis_if.s_axis_config_tvalid = 1'b1;
      chk({tag, "_tready"}, 32'(axis_if.s_axis_reload_tready), 1);
      if (cfg_at >= 0 && i >= cfg_at) begin
        chk({tag, "_cfg_hold"}, 32'(axis_if.s_axis_config_tready), 0);
      end
      if (i < NumTaps) ref_mem[~ref_bank][tap_addr(i)] = base + i;
      step();
      chk({tag, "_done"}, 32'(done), 32'(with_last && i == n - 1 && n == NumTaps));
      chk({tag, "_err_short"}, 32'(e_short), 32'(with_last && i == n - 1 && n < NumTaps));
      chk({tag, "_err_long"}, 32'(e_long), 32'(with_last && i == n - 1 && n > NumTaps));
    end
    axis_if.s_axis_reload_tvalid = 1'b0;
    axis_if.s_axis_reload_tlast  = 1'b0;
  endtask

  task automatic send_config(input logic [CfgW-1:0] w);
    axis_if.s_axis_config_tdata  = w;
    axis_if.s_axis_config_tvalid = 1'b1;
    step();
    axis_if.s_axis_config_tvalid = 1'b0;
  endtask

  initial begin
    rst_n                        = 1'b0;
    axis_if.s_axis_reload_tdata  = '0;
    axis_if.s_axis_reload_tlast  = 1'b0;
    axis_if.s_axis_reload_tvalid = 1'b0;
    axis_if.s_axis_config_tdata  = '0;
    axis_if.s_axis_config_tvalid = 1'b0;
    raddr                        = '0;
    ref_bank                     = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    chk("rst_bank", 32'(bank), 0);
    chk("rst_cfg_word", 32'(cfg_word), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err_short", 32'(e_short), 0);
    chk("rst_err_long", 32'(e_long), 0);
    chk("rst_reload_tready", 32'(axis_if.s_axis_reload_tready), 1);
    chk("rst_cfg_tready", 32'(axis_if.s_axis_config_tready), 1);

    // Full packet, then swap
    send_packet(NumTaps, 0, -1, 1'b1, "t1");
    chk("t1_full_tready", 32'(axis_if.s_axis_reload_tready), 0);
    chk("t1_full_cfg_tready", 32'(axis_if.s_axis_config_tready), 1);
    step();
    chk("t1_done_single", 32'(done), 0);
    chk("t1_bank_before", 32'(bank), 0);
    send_config(8'h00);
    ref_bank = ~ref_bank;
    chk("t1_bank_after", 32'(bank), 1);
    chk("t1_cfg_word", 32'(cfg_word), 0);
    chk("t1_idle_tready", 32'(axis_if.s_axis_reload_tready), 1);
    read_issue(5);
    step();
    read_check("t1_rd5");
    read_issue(0);
    step();
    read_check("t1_rd0");
    read_issue(128);
    step();
    read_check("t1_rd128");

    // Short packet leaves the active bank alone
    send_packet(100, 1000, -1, 1'b1, "t2");
    chk("t2_bank", 32'(bank), 1);
    step();
    chk("t2_err_short_single", 32'(e_short), 0);
    read_issue(5);
    step();
    read_check("t2_rd5");
    send_config(8'hA5);
    chk("t2_cfg_word", 32'(cfg_word), 32'h A5);
    chk("t2_cfg_idle_bank", 32'(bank), 1);

    // Overlong packet drains to tlast
    send_packet(140, 2000, -1, 1'b1, "t3");
    step();
    chk("t3_err_long_single", 32'(e_long), 0);
    chk("t3_no_done", 32'(done), 0);
    chk("t3_bank", 32'(bank), 1);
    chk("t3_idle_tready", 32'(axis_if.s_axis_reload_tready), 1);

    // Config held from mid-packet, swap across back-to-back reads
    axis_if.s_axis_config_tdata = 8'h3C;
    send_packet(NumTaps, 3000, 40, 1'b1, "t4");
    chk("t4_cfg_tready_full", 32'(axis_if.s_axis_config_tready), 1);
    chk("t4_full_tready", 32'(axis_if.s_axis_reload_tready), 0);
    chk("t4_cfg_word_held", 32'(cfg_word), 32'h A5);
    read_issue(5);
    step();
    axis_if.s_axis_config_tvalid = 1'b0;
    read_check("t4_rd_old_bank");
    chk("t4_bank_swapped", 32'(bank), 0);
    chk("t4_cfg_word", 32'(cfg_word), 32'h 3C);
    ref_bank = ~ref_bank;
    read_issue(5);
    step();
    read_check("t4_rd_new_bank");
    chk("t4_bank_once", 32'(bank), 0);
    read_issue(129);
    step();
    read_check("t4_rd129");
    read_issue(255);
    step();
    read_check("t4_rd255");
    read_issue(100);
    step();
    read_check("t4_rd100");
    chk("t4_bank_stable", 32'(bank), 0);

    // Reset mid-packet, then a clean reload
    send_packet(60, 5000, -1, 1'b0, "t5a");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ref_bank = 1'b0;
    chk("t5_rst_bank", 32'(bank), 0);
    chk("t5_rst_rdata", 32'(rdata), 0);
    chk("t5_rst_cfg_word", 32'(cfg_word), 0);
    chk("t5_rst_err_short", 32'(e_short), 0);
    chk("t5_rst_err_long", 32'(e_long), 0);
    chk("t5_rst_tready", 32'(axis_if.s_axis_reload_tready), 1);
    send_packet(NumTaps, 6000, -1, 1'b1, "t5b");
    send_config(8'h11);
    ref_bank = ~ref_bank;
    chk("t5_bank", 32'(bank), 1);
    chk("t5_cfg_word", 32'(cfg_word), 32'h 11);
    read_issue(5);
    step();
    read_check("t5_rd5");
    read_issue(64);
    step();
    read_check("t5_rd64");

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
